// File: rtl/shapool_sequencer_if.sv
// ---------------------------------------------------------------------------
// shapool_sequencer_if
//
// Signal bundle between the IO/host side and the shapool job sequencer,
// including the hash-core facing lines.
//
//   start        host -> seq  launch a job
//   halt         host -> seq  external stop
//   nonce_start  host -> seq  per-device range selector
//   core_success core -> seq  hash result meets difficulty
//   core_en      seq -> core  advance hash pipeline
//   core_clear   seq -> core  one-cycle pipeline flush
//   core_nonce   seq -> core  nonce presented to core
//   result_nonce seq -> host  winning nonce (valid when found)
//   busy/done/found/exhausted seq -> host status
//
// Modports: master = host/core side, slave = sequencer.
// ---------------------------------------------------------------------------
interface shapool_sequencer_if #(
    parameter int NONCE_START_WIDTH = 8,
    parameter int CW                = 30
) ();
    logic                         start;
    logic                         halt;
    logic [NONCE_START_WIDTH-1:0] nonce_start;
    logic                         core_success;
    logic                         core_en;
    logic                         core_clear;
    logic [CW-1:0]                core_nonce;
    logic [CW-1:0]                result_nonce;
    logic                         busy;
    logic                         done;
    logic                         found;
    logic                         exhausted;

    modport master (
        output start, halt, nonce_start, core_success,
        input  core_en, core_clear, core_nonce, result_nonce,
               busy, done, found, exhausted
    );

    modport slave (
        input  start, halt, nonce_start, core_success,
        output core_en, core_clear, core_nonce, result_nonce,
               busy, done, found, exhausted
    );
endinterface

// File: rtl/shapool_sequencer.sv
// ---------------------------------------------------------------------------
// shapool_sequencer
//
// Job sequencer for the shapool hash core. On start it flushes the pipeline,
// issues this device's nonce range one nonce per cycle, ignores results until
// the pipeline has filled, then tracks which nonce each core_success belongs
// to. Stops on success, range exhaustion or external halt and reports the
// exact winning nonce.
//
// Ports:
//   clk      clock
//   reset_n  synchronous, active-low reset
//   bus      shapool_sequencer_if.slave (job control, core lines, status)
// ---------------------------------------------------------------------------
module shapool_sequencer #(
    parameter int NONCE_WIDTH       = 32,
    parameter int POOL_SIZE_LOG2    = 2,
    parameter int NONCE_START_WIDTH = 8,
    parameter int PIPE_LATENCY      = 128
) (
    input  logic                   clk,
    input  logic                   reset_n,
    shapool_sequencer_if.slave     bus
);
    localparam int CW = NONCE_WIDTH - POOL_SIZE_LOG2;
    localparam int LW = CW - NONCE_START_WIDTH;
    localparam int FW = $clog2(PIPE_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        RUN,
        FOUND,
        EXHAUSTED,
        HALTED
    } state_t;

    state_t        state_reg,  state_next;
    logic [CW-1:0] issue_reg,  issue_next;
    logic [CW-1:0] check_reg,  check_next;
    logic [FW-1:0] fill_reg,   fill_next;
    logic [CW-1:0] result_reg, result_next;

    logic [CW-1:0] load_base;
    logic [CW-1:0] issue_inc;
    logic [CW-1:0] run_base;

    assign load_base = {bus.nonce_start, {LW{1'b0}}};

    // Issue counter holds on the last nonce of the range so the core never
    // sees a neighbouring device's nonces.
    assign issue_inc = (&issue_reg[LW-1:0]) ? issue_reg : issue_reg + 1'b1;

    // The issue counter never leaves the range, so its upper field is the
    // range selector captured in LOAD; no separate base register is needed.
    assign run_base = {issue_reg[CW-1:LW], {LW{1'b0}}};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            issue_reg  <= '0;
            check_reg  <= '0;
            fill_reg   <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            issue_reg  <= issue_next;
            check_reg  <= check_next;
            fill_reg   <= fill_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        issue_next  = issue_reg;
        check_next  = check_reg;
        fill_next   = fill_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next  = LOAD;
                    result_next = '0;
                end
            end
            LOAD: begin
                issue_next = load_base;
                fill_next  = '0;
                state_next = FILL;
            end
            FILL: begin
                issue_next = issue_inc;
                fill_next  = fill_reg + 1'b1;
                if (bus.halt) begin
                    state_next = HALTED;
                end else if (fill_reg == FW'(PIPE_LATENCY - 1)) begin
                    state_next = RUN;
                    check_next = run_base;
                end
            end
            RUN: begin
                issue_next = issue_inc;
                check_next = check_reg + 1'b1;
                // Success outranks halt and exhaustion: a hit on the last
                // nonce still reports FOUND.
                if (bus.core_success) begin
                    state_next  = FOUND;
                    result_next = check_reg;
                end else if (bus.halt) begin
                    state_next = HALTED;
                end else if (&check_reg[LW-1:0]) begin
                    state_next = EXHAUSTED;
                end
            end
            FOUND, EXHAUSTED, HALTED: begin
                if (bus.start) begin
                    state_next  = LOAD;
                    result_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs are decoded from registered state/counters only.
    assign bus.core_en      = (state_reg == FILL) || (state_reg == RUN);
    assign bus.core_clear   = (state_reg == LOAD);
    assign bus.core_nonce   = issue_reg;
    assign bus.result_nonce = result_reg;
    assign bus.busy         = (state_reg == LOAD) || (state_reg == FILL) ||
                              (state_reg == RUN);
    assign bus.done         = (state_reg == FOUND) || (state_reg == EXHAUSTED) ||
                              (state_reg == HALTED);
    assign bus.found        = (state_reg == FOUND);
    assign bus.exhausted    = (state_reg == EXHAUSTED);

endmodule

// File: tb/tb_shapool_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shapool_sequencer
//
// Directed bench for shapool_sequencer with NONCE_WIDTH=16, POOL_SIZE_LOG2=2,
// NONCE_START_WIDTH=8, PIPE_LATENCY=4 (CW=14, LW=6). Inputs are driven and
// outputs sampled on the falling edge; the DUT registers on the rising edge.
// From a LOAD cycle, FILL cycle j is j+1 falling edges later and RUN cycle k
// is 5+k falling edges later.
// ---------------------------------------------------------------------------
module tb_shapool_sequencer;
    localparam int NONCE_WIDTH       = 16;
    localparam int POOL_SIZE_LOG2    = 2;
    localparam int NONCE_START_WIDTH = 8;
    localparam int PIPE_LATENCY      = 4;
    localparam int CW                = NONCE_WIDTH - POOL_SIZE_LOG2;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    shapool_sequencer_if #(
        .NONCE_START_WIDTH (NONCE_START_WIDTH),
        .CW                (CW)
    ) bus ();

    shapool_sequencer #(
        .NONCE_WIDTH       (NONCE_WIDTH),
        .POOL_SIZE_LOG2    (POOL_SIZE_LOG2),
        .NONCE_START_WIDTH (NONCE_START_WIDTH),
        .PIPE_LATENCY      (PIPE_LATENCY)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulses start with the given selector; returns during the LOAD cycle.
    task automatic launch(input logic [7:0] ns);
        @(negedge clk);
        bus.nonce_start = ns;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        $display("launch nonce_start=%02h", ns);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(1);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.found !== 1'b0 ||
            bus.exhausted !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got busy=%b done=%b found=%b exh=%b want 0000",
                     bus.busy, bus.done, bus.found, bus.exhausted);
        end
        checks++;
        if (bus.core_en !== 1'b0 || bus.core_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_core got en=%b clr=%b want 00", bus.core_en, bus.core_clear);
        end
        checks++;
        if (bus.core_nonce !== 14'h0000 || bus.result_nonce !== 14'h0000) begin
            errors++;
            $display("FAIL reset_nonce got core=%h result=%h want 0000 0000",
                     bus.core_nonce, bus.result_nonce);
        end
        $display("reset done");
    endtask

    task automatic test_find();
        launch(8'h03);
        checks++;
        if (bus.core_clear !== 1'b1 || bus.core_en !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL find_load got clr=%b en=%b busy=%b want 101",
                     bus.core_clear, bus.core_en, bus.busy);
        end
        step(1); // FILL0
        checks++;
        if (bus.core_nonce !== 14'h00C0 || bus.core_en !== 1'b1 || bus.core_clear !== 1'b0) begin
            errors++;
            $display("FAIL find_fill0 got nonce=%h en=%b clr=%b want 00c0 1 0",
                     bus.core_nonce, bus.core_en, bus.core_clear);
        end
        step(1); // FILL1: start while busy must be ignored
        bus.nonce_start = 8'h55;
        bus.start       = 1'b1;
        step(1); // FILL2
        bus.start       = 1'b0;
        bus.nonce_start = 8'h03;
        checks++;
        if (bus.core_nonce !== 14'h00C2 || bus.core_clear !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy got nonce=%h clr=%b busy=%b want 00c2 0 1",
                     bus.core_nonce, bus.core_clear, bus.busy);
        end
        step(2); // RUN0
        checks++;
        if (bus.core_nonce !== 14'h00C4 || bus.core_en !== 1'b1) begin
            errors++;
            $display("FAIL find_run0 got nonce=%h en=%b want 00c4 1", bus.core_nonce, bus.core_en);
        end
        step(5); // RUN5
        bus.core_success = 1'b1;
        step(1);
        bus.core_success = 1'b0;
        checks++;
        if (bus.found !== 1'b1 || bus.done !== 1'b1 || bus.core_en !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL find_status got found=%b done=%b en=%b busy=%b want 1100",
                     bus.found, bus.done, bus.core_en, bus.busy);
        end
        checks++;
        if (bus.result_nonce !== 14'h00C5) begin
            errors++;
            $display("FAIL find_result got %h want 00c5", bus.result_nonce);
        end
    endtask

    task automatic test_exhaust();
        int n;
        logic [CW-1:0] max_nonce;
        launch(8'h03);
        n = 0;
        max_nonce = '0;
        while (bus.exhausted !== 1'b1 && n < 200) begin
            step(1);
            n++;
            if (bus.core_nonce > max_nonce) max_nonce = bus.core_nonce;
        end
        checks++;
        if (n !== 69) begin
            errors++;
            $display("FAIL exhaust_cycles got %0d want 69", n);
        end
        checks++;
        if (max_nonce !== 14'h00FF) begin
            errors++;
            $display("FAIL exhaust_max_nonce got %h want 00ff", max_nonce);
        end
        checks++;
        if (bus.found !== 1'b0 || bus.done !== 1'b1 || bus.core_en !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_status got found=%b done=%b en=%b want 010",
                     bus.found, bus.done, bus.core_en);
        end
    endtask

    task automatic test_last_nonce();
        launch(8'h03);
        step(5 + 63); // RUN63
        checks++;
        if (bus.core_nonce !== 14'h00FF || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL last_saturate got nonce=%h busy=%b want 00ff 1",
                     bus.core_nonce, bus.busy);
        end
        bus.core_success = 1'b1;
        step(1);
        bus.core_success = 1'b0;
        checks++;
        if (bus.found !== 1'b1 || bus.exhausted !== 1'b0 || bus.result_nonce !== 14'h00FF) begin
            errors++;
            $display("FAIL last_nonce got found=%b exh=%b result=%h want 1 0 00ff",
                     bus.found, bus.exhausted, bus.result_nonce);
        end
    endtask

    task automatic test_halt();
        launch(8'h03);
        step(3); // FILL2
        bus.halt = 1'b1;
        step(1);
        bus.halt = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.found !== 1'b0 || bus.exhausted !== 1'b0 ||
            bus.core_en !== 1'b0 || bus.result_nonce !== 14'h0000) begin
            errors++;
            $display("FAIL halt_fill got done=%b found=%b exh=%b en=%b result=%h want 1 0 0 0 0000",
                     bus.done, bus.found, bus.exhausted, bus.core_en, bus.result_nonce);
        end
        launch(8'h03);
        step(5 + 10); // RUN10
        bus.halt         = 1'b1;
        bus.core_success = 1'b1;
        step(1);
        bus.halt         = 1'b0;
        bus.core_success = 1'b0;
        checks++;
        if (bus.found !== 1'b1 || bus.result_nonce !== 14'h00CA) begin
            errors++;
            $display("FAIL halt_vs_success got found=%b result=%h want 1 00ca",
                     bus.found, bus.result_nonce);
        end
        // halt alone in a terminal state is ignored
        bus.halt = 1'b1;
        step(1);
        bus.halt = 1'b0;
        checks++;
        if (bus.found !== 1'b1 || bus.result_nonce !== 14'h00CA || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL terminal_halt got found=%b result=%h busy=%b want 1 00ca 0",
                     bus.found, bus.result_nonce, bus.busy);
        end
        // halt together with start in a terminal state relaunches
        bus.halt        = 1'b1;
        bus.start       = 1'b1;
        bus.nonce_start = 8'h03;
        step(1);
        bus.halt  = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.core_clear !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL halt_start got clr=%b busy=%b done=%b want 1 1 0",
                     bus.core_clear, bus.busy, bus.done);
        end
    endtask

    task automatic test_midrun_reset();
        // Continues from the LOAD entered at the end of test_halt.
        step(5 + 20); // RUN20
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.core_en !== 1'b0 ||
            bus.core_nonce !== 14'h0000 || bus.result_nonce !== 14'h0000) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b en=%b nonce=%h result=%h want 0 0 0 0000 0000",
                     bus.busy, bus.done, bus.core_en, bus.core_nonce, bus.result_nonce);
        end
        launch(8'h03);
        step(5 + 2); // RUN2
        bus.core_success = 1'b1;
        step(1);
        bus.core_success = 1'b0;
        checks++;
        if (bus.found !== 1'b1 || bus.result_nonce !== 14'h00C2) begin
            errors++;
            $display("FAIL relaunch_find got found=%b result=%h want 1 00c2",
                     bus.found, bus.result_nonce);
        end
        launch(8'h01);
        checks++;
        if (bus.core_clear !== 1'b1 || bus.found !== 1'b0) begin
            errors++;
            $display("FAIL relaunch_load got clr=%b found=%b want 1 0", bus.core_clear, bus.found);
        end
        step(1); // FILL0
        checks++;
        if (bus.core_nonce !== 14'h0040 || bus.result_nonce !== 14'h0000) begin
            errors++;
            $display("FAIL relaunch_fill0 got nonce=%h result=%h want 0040 0000",
                     bus.core_nonce, bus.result_nonce);
        end
        step(4); // RUN0
        bus.core_success = 1'b1;
        step(1);
        bus.core_success = 1'b0;
        checks++;
        if (bus.found !== 1'b1 || bus.result_nonce !== 14'h0040) begin
            errors++;
            $display("FAIL relaunch_run0 got found=%b result=%h want 1 0040",
                     bus.found, bus.result_nonce);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.halt         = 1'b0;
        bus.nonce_start  = 8'h00;
        bus.core_success = 1'b0;

        test_reset();
        test_find();
        test_exhaust();
        test_last_nonce();
        test_halt();
        test_midrun_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
